// File: rtl/deflect_port_alloc_if.sv
// Per-cycle allocation bundle for deflect_port_alloc.
// The master drives the flits and port availability, and the slave returns the registered grants and statistics.
interface deflect_port_alloc_if #(
  parameter int unsigned NUM_PORT = 5,
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned CNT_W    = 16
);
  logic [NUM_IN-1:0]              in_valid;
  logic [NUM_IN*(NUM_PORT-1)-1:0] req;
  logic [NUM_PORT-1:0]            avail;
  logic                           stat_clr;
  logic [NUM_IN*NUM_PORT-1:0]     alloc;
  logic [NUM_IN-1:0]              alloc_valid;
  logic [NUM_IN-1:0]              deflected;
  logic [CNT_W-1:0]               deflect_cnt;
  logic                           overflow;

  modport master (
    output in_valid, req, avail, stat_clr,
    input  alloc, alloc_valid, deflected, deflect_cnt, overflow
  );

  modport slave (
    input  in_valid, req, avail, stat_clr,
    output alloc, alloc_valid, deflected, deflect_cnt, overflow
  );
endinterface

// File: rtl/deflect_port_alloc.sv
// Registered last-stage port allocator for the bufferless deflection router.
// It makes a productive grant when possible, otherwise a round-robin deflection, and rotates priority toward starving channels.
module deflect_port_alloc #(
  parameter int unsigned NUM_PORT  = 5,
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned STARVE_TH = 3,
  parameter int unsigned CNT_W     = 16
) (
  input logic                 clk,
  input logic                 reset,
  deflect_port_alloc_if.slave bus
);
  localparam int unsigned NR = NUM_PORT - 1;
  localparam int unsigned RW = $clog2(NUM_PORT);
  localparam int unsigned PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned TW = $clog2(STARVE_TH + 1);
  localparam int unsigned SW = CNT_W + $clog2(NUM_IN + 1);

  logic [RW-1:0]              rr, rr_nxt;
  logic [PW-1:0]              prio, prio_nxt;
  logic [TW-1:0]              starve     [NUM_IN];
  logic [TW-1:0]              starve_nxt [NUM_IN];
  logic [NUM_IN*NUM_PORT-1:0] alloc_r, alloc_nxt;
  logic [NUM_IN-1:0]          gv_r, gv_nxt, dfl_r, dfl_nxt;
  logic [CNT_W-1:0]           cnt_r;
  logic                       ovf_r, ovf_now;
  logic [SW-1:0]              sum;

  // Flits are visited in service order by matching each position against every index,
  // so that no array is indexed by a runtime value.
  always_comb begin
    logic [NUM_PORT-1:0] rem, pm, pick;
    logic                found, hit;
    int unsigned         last;
    rem       = bus.avail;
    pm        = '0;
    pick      = '0;
    found     = 1'b0;
    hit       = 1'b0;
    last      = 0;
    alloc_nxt = '0;
    gv_nxt    = '0;
    dfl_nxt   = '0;
    ovf_now   = 1'b0;
    rr_nxt    = rr;
    prio_nxt  = prio;
    for (int unsigned i = 0; i < NUM_IN; i++) starve_nxt[i] = starve[i];

    for (int unsigned k = 0; k < NUM_IN; k++) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (i == (32'(prio) + k) % NUM_IN && bus.in_valid[i]) begin
          pm    = {1'b0, bus.req[i*NR +: NR]} & rem;
          pick  = '0;
          found = 1'b0;
          for (int unsigned q = 0; q < NUM_PORT; q++) begin
            if (pm[q]) begin
              pick    = '0;
              pick[q] = 1'b1;
              found   = 1'b1;
            end
          end
          if (found) begin
            starve_nxt[i] = '0;
          end else begin
            for (int unsigned j = 0; j < NUM_PORT; j++) begin
              for (int unsigned q = 0; q < NUM_PORT; q++) begin
                if (!found && rem[q] && q == (32'(rr) + j) % NUM_PORT) begin
                  pick[q] = 1'b1;
                  found   = 1'b1;
                  last    = q;
                end
              end
            end
            if (found) begin
              dfl_nxt[i] = 1'b1;
              rr_nxt     = RW'((last + 1) % NUM_PORT);
              if (starve[i] != TW'(STARVE_TH)) starve_nxt[i] = starve[i] + TW'(1);
            end else begin
              ovf_now = 1'b1;
            end
          end
          gv_nxt[i]                         = found;
          alloc_nxt[i*NUM_PORT +: NUM_PORT] = pick;
          rem                               = rem & ~pick;
        end
      end
    end

    // The lowest channel whose updated counter reaches the threshold takes top priority.
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (!hit && starve_nxt[i] == TW'(STARVE_TH)) begin
        hit           = 1'b1;
        prio_nxt      = PW'(i);
        starve_nxt[i] = '0;
      end
    end

    sum = SW'(cnt_r);
    for (int unsigned i = 0; i < NUM_IN; i++) sum = sum + SW'(dfl_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_r <= '0;
      gv_r    <= '0;
      dfl_r   <= '0;
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
      rr      <= '0;
      prio    <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) starve[i] <= '0;
    end else begin
      alloc_r <= alloc_nxt;
      gv_r    <= gv_nxt;
      dfl_r   <= dfl_nxt;
      rr      <= rr_nxt;
      prio    <= prio_nxt;
      for (int unsigned i = 0; i < NUM_IN; i++) starve[i] <= starve_nxt[i];
      if (bus.stat_clr) begin
        cnt_r <= '0;
        ovf_r <= 1'b0;
      end else begin
        cnt_r <= (sum > SW'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
        ovf_r <= ovf_r | ovf_now;
      end
    end
  end

  assign bus.alloc       = alloc_r;
  assign bus.alloc_valid = gv_r;
  assign bus.deflected   = dfl_r;
  assign bus.deflect_cnt = cnt_r;
  assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_deflect_port_alloc.sv
// Bench for deflect_port_alloc: directed vectors, corner sequences and random traffic against a reference model.
// A second instance with a 4-bit counter mirrors the stimulus to exercise counter saturation.
module tb_deflect_port_alloc;
  localparam int NP = 5;
  localparam int NI = 4;
  localparam int TH = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  deflect_port_alloc_if #(.NUM_PORT(NP), .NUM_IN(NI), .CNT_W(16)) bus ();
  deflect_port_alloc_if #(.NUM_PORT(NP), .NUM_IN(NI), .CNT_W(4))  bus4 ();

  assign bus4.in_valid = bus.in_valid;
  assign bus4.req      = bus.req;
  assign bus4.avail    = bus.avail;
  assign bus4.stat_clr = bus.stat_clr;

  deflect_port_alloc #(.NUM_PORT(NP), .NUM_IN(NI), .STARVE_TH(TH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  deflect_port_alloc #(.NUM_PORT(NP), .NUM_IN(NI), .STARVE_TH(TH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  // Reference state, as plain integers
  int          m_prio, m_rr, m_cnt, m_cnt4;
  int          m_starve [NI];
  bit          m_ovf;
  logic [19:0] e_alloc;
  logic [3:0]  e_gv, e_dfl;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] rq;
    logic [4:0]  av;
    logic        clr;
    logic [19:0] alloc;
    logic [3:0]  gv;
    logic [3:0]  dfl;
    logic [15:0] cnt;
    logic        ovf;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_rr = 0; m_cnt = 0; m_cnt4 = 0; m_ovf = 0;
    for (int f = 0; f < NI; f++) m_starve[f] = 0;
  endtask

  task automatic model_step(input logic [3:0] v, input logic [15:0] rq,
                            input logic [4:0] av, input logic clr);
    bit free [NP];
    int nd, port, lastp, f, p;
    bit d, any_ovf, found;
    for (int q = 0; q < NP; q++) free[q] = av[q];
    e_alloc = '0; e_gv = '0; e_dfl = '0;
    nd = 0; any_ovf = 0; lastp = 0;
    for (int k = 0; k < NI; k++) begin
      f = (m_prio + k) % NI;
      if (v[f]) begin
        port = -1;
        d    = 0;
        for (int q = NP - 2; q >= 0; q--)
          if (port < 0 && free[q] && rq[f*(NP-1) + q]) port = q;
        if (port < 0) begin
          for (int s = 0; s < NP; s++) begin
            p = (m_rr + s) % NP;
            if (port < 0 && free[p]) begin
              port = p;
              d    = 1;
            end
          end
        end
        if (port < 0) begin
          any_ovf = 1;
        end else begin
          free[port] = 0;
          e_alloc[f*NP + port] = 1'b1;
          e_gv[f] = 1'b1;
          if (d) begin
            e_dfl[f] = 1'b1;
            nd++;
            lastp = port;
            m_starve[f] = (m_starve[f] + 1 > TH) ? TH : m_starve[f] + 1;
          end else begin
            m_starve[f] = 0;
          end
        end
      end
    end
    if (nd > 0) m_rr = (lastp + 1) % NP;
    found = 0;
    for (int g = 0; g < NI; g++) begin
      if (!found && m_starve[g] == TH) begin
        found = 1;
        m_prio = g;
        m_starve[g] = 0;
      end
    end
    if (clr) begin
      m_cnt = 0; m_cnt4 = 0; m_ovf = 0;
    end else begin
      m_cnt  = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
      m_cnt4 = (m_cnt4 + nd > 15) ? 15 : m_cnt4 + nd;
      m_ovf  = m_ovf | any_ovf;
    end
  endtask

  // Drive at the falling edge, let the rising edge sample, then compare at the next falling edge.
  task automatic step(input logic [3:0] v, input logic [15:0] rq,
                      input logic [4:0] av, input logic clr);
    bus.in_valid = v;
    bus.req      = rq;
    bus.avail    = av;
    bus.stat_clr = clr;
    model_step(v, rq, av, clr);
    @(negedge clk);
    check("alloc",       32'(bus.alloc),        32'(e_alloc));
    check("alloc_valid", 32'(bus.alloc_valid),  32'(e_gv));
    check("deflected",   32'(bus.deflected),    32'(e_dfl));
    check("deflect_cnt", 32'(bus.deflect_cnt),  32'(m_cnt));
    check("overflow",    32'(bus.overflow),     32'(m_ovf));
    check("cnt4",        32'(bus4.deflect_cnt), 32'(m_cnt4));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  rv;
    logic [15:0] rrq;
    logic [4:0]  rav;

    bus.in_valid = '0; bus.req = '0; bus.avail = '0; bus.stat_clr = 1'b0;
    tbl[0] = '{v: 4'b0001, rq: 16'h0006, av: 5'b11111, clr: 1'b0,
               alloc: 20'h00004, gv: 4'b0001, dfl: 4'b0000, cnt: 16'd0, ovf: 1'b0};
    tbl[1] = '{v: 4'b0011, rq: 16'h0022, av: 5'b11111, clr: 1'b0,
               alloc: 20'h00022, gv: 4'b0011, dfl: 4'b0010, cnt: 16'd1, ovf: 1'b0};
    tbl[2] = '{v: 4'b0011, rq: 16'h0022, av: 5'b11111, clr: 1'b0,
               alloc: 20'h00082, gv: 4'b0011, dfl: 4'b0010, cnt: 16'd2, ovf: 1'b0};
    tbl[3] = '{v: 4'b0000, rq: 16'hffff, av: 5'b11111, clr: 1'b0,
               alloc: 20'h00000, gv: 4'b0000, dfl: 4'b0000, cnt: 16'd2, ovf: 1'b0};

    do_reset();
    check("reset_alloc", 32'(bus.alloc),       32'd0);
    check("reset_cnt",   32'(bus.deflect_cnt), 32'd0);

    for (int i = 0; i < 4; i++) begin
      step(tbl[i].v, tbl[i].rq, tbl[i].av, tbl[i].clr);
      check("tbl_alloc", 32'(bus.alloc),       32'(tbl[i].alloc));
      check("tbl_gv",    32'(bus.alloc_valid), 32'(tbl[i].gv));
      check("tbl_dfl",   32'(bus.deflected),   32'(tbl[i].dfl));
      check("tbl_cnt",   32'(bus.deflect_cnt), 32'(tbl[i].cnt));
      check("tbl_ovf",   32'(bus.overflow),    32'(tbl[i].ovf));
    end

    // Asynchronous reset in mid-cycle while traffic is flowing
    step(4'b0011, 16'h0022, 5'b11111, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_alloc", 32'(bus.alloc),       32'd0);
    check("async_gv",    32'(bus.alloc_valid), 32'd0);
    check("async_dfl",   32'(bus.deflected),   32'd0);
    check("async_cnt",   32'(bus.deflect_cnt), 32'd0);
    check("async_ovf",   32'(bus.overflow),    32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Starvation: flit2 keeps losing port0 until it takes priority
    for (int c = 1; c <= 4; c++) begin
      step(4'b0101, 16'h0101, 5'b11111, 1'b0);
      if (c <= 3) begin
        check("starve_dfl", 32'(bus.deflected), 32'b0100);
      end else begin
        check("starve_win", 32'(bus.alloc[14:10]), 32'b00001);
        check("starve_dfl", 32'(bus.deflected),    32'b0001);
      end
    end

    // Overflow: only two ports free for four flits
    do_reset();
    step(4'b1111, 16'h0000, 5'b00011, 1'b0);
    check("ovf_gv",   32'(bus.alloc_valid), 32'b0011);
    check("ovf_set",  32'(bus.overflow),    32'd1);
    step(4'b0000, 16'h0000, 5'b11111, 1'b0);
    check("ovf_hold", 32'(bus.overflow),    32'd1);
    step(4'b0000, 16'h0000, 5'b11111, 1'b1);
    check("ovf_clr",  32'(bus.overflow),    32'd0);

    // Saturation of the narrow counter: two deflections per cycle
    for (int c = 0; c < 9; c++) step(4'b0011, 16'h0000, 5'b11111, 1'b0);
    check("sat_cnt4",  32'(bus4.deflect_cnt), 32'd15);
    step(4'b0011, 16'h0000, 5'b11111, 1'b0);
    check("sat_hold4", 32'(bus4.deflect_cnt), 32'd15);
    step(4'b0011, 16'h0000, 5'b11111, 1'b1);
    check("sat_clr4",  32'(bus4.deflect_cnt), 32'd0);
    check("sat_clr16", 32'(bus.deflect_cnt),  32'd0);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      rv  = 4'($urandom);
      rrq = 16'($urandom);
      rav = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom);
      step(rv, rrq, rav, ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
